// File: rtl/optical_nxn_xbar_cfg_ctrl.sv
// N-port optical crosspoint configuration controller: validates a destination permutation,
// drives BAR/CROSS crosspoints, then sequences settling and the completion handshake.
// Optional: define OPT_XBAR_SKIP_SAME_EN to complete unchanged configurations without re-driving.
module optical_nxn_xbar_cfg_ctrl #(
   parameter int   P_PORTS      = 8,
   parameter int   P_W          = $clog2(P_PORTS),
   parameter logic P_BAR        = 1'b0,
   parameter logic P_CROSS      = 1'b1,
   parameter int   P_SETTLE_CYC = 16,
   parameter int   P_TIMEOUT    = 1024
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [P_PORTS*P_W-1:0]       i_req,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   output logic [P_PORTS*P_PORTS-1:0]   o_switch_grant,
   output logic                         o_grant_valid,
   input  logic                         i_config_end,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_err,
   output logic [1:0]                   o_err_code
);

   localparam int C_MAX = (P_SETTLE_CYC > P_TIMEOUT) ? P_SETTLE_CYC : P_TIMEOUT;
   localparam int C_CW  = $clog2(C_MAX + 1);
   localparam logic [C_CW-1:0] C_SETTLE_LAST = C_CW'(P_SETTLE_CYC - 1);
   localparam logic [C_CW-1:0] C_TO_LAST     = C_CW'((P_TIMEOUT == 0) ? 0 : P_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_DRIVE,
      S_SETTLE,
      S_WAIT_END
   } state_t;

   state_t                       state;
   logic [P_PORTS*P_W-1:0]       req_q;
   logic [C_CW-1:0]              cnt;
   logic [P_PORTS*P_PORTS-1:0]   mat;
   logic [P_PORTS-1:0]           used;
   logic                         conflict;
   logic [P_W-1:0]               dest;

   // Matrix and column-conflict flag from the latched request; an output already
   // claimed by a lower-numbered input marks a duplicate destination.
   always_comb begin
      mat      = {(P_PORTS*P_PORTS){P_BAR}};
      used     = '0;
      conflict = 1'b0;
      dest     = '0;
      for (int unsigned i = 0; i < P_PORTS; i++) begin
         dest = req_q[i*P_W +: P_W];
         if (used[dest]) conflict = 1'b1;
         used[dest] = 1'b1;
         mat[i*P_PORTS + 32'(dest)] = P_CROSS;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_IDLE;
         req_q          <= '0;
         cnt            <= '0;
         o_switch_grant <= {(P_PORTS*P_PORTS){P_BAR}};
         o_req_ready    <= 1'b1;
         o_grant_valid  <= 1'b0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_err          <= 1'b0;
         o_err_code     <= 2'b00;
      end else begin
         o_grant_valid <= 1'b0;
         o_done        <= 1'b0;
         o_err         <= 1'b0;
         o_err_code    <= 2'b00;
         case (state)
            S_IDLE: begin
               if (i_req_valid && o_req_ready) begin
                  req_q       <= i_req;
                  state       <= S_CHECK;
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            S_CHECK: begin
               if (conflict) begin
                  o_err       <= 1'b1;
                  o_err_code  <= 2'b01;
                  state       <= S_IDLE;
                  o_req_ready <= 1'b1;
                  o_busy      <= 1'b0;
               end
`ifdef OPT_XBAR_SKIP_SAME_EN
               else if (mat == o_switch_grant) begin
                  o_done      <= 1'b1;
                  state       <= S_IDLE;
                  o_req_ready <= 1'b1;
                  o_busy      <= 1'b0;
               end
`endif
               else begin
                  o_switch_grant <= mat;
                  o_grant_valid  <= 1'b1;
                  state          <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               cnt   <= '0;
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == C_SETTLE_LAST) begin
                  cnt   <= '0;
                  state <= S_WAIT_END;
               end else begin
                  cnt <= cnt + C_CW'(1);
               end
            end
            S_WAIT_END: begin
               if (i_config_end) begin
                  o_done      <= 1'b1;
                  state       <= S_IDLE;
                  o_req_ready <= 1'b1;
                  o_busy      <= 1'b0;
               end else if (P_TIMEOUT != 0 && cnt == C_TO_LAST) begin
                  o_err       <= 1'b1;
                  o_err_code  <= 2'b10;
                  state       <= S_IDLE;
                  o_req_ready <= 1'b1;
                  o_busy      <= 1'b0;
               end else if (P_TIMEOUT != 0) begin
                  cnt <= cnt + C_CW'(1);
               end
            end
            default: begin
               state       <= S_IDLE;
               o_req_ready <= 1'b1;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_optical_nxn_xbar_cfg_ctrl.sv
// Directed self-checking bench for optical_nxn_xbar_cfg_ctrl (4 ports, settle 4, timeout 16).
module tb_optical_nxn_xbar_cfg_ctrl;

   logic        i_clk;
   logic        i_rst_n;
   logic [7:0]  i_req;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [15:0] o_switch_grant;
   logic        o_grant_valid;
   logic        i_config_end;
   logic        o_busy;
   logic        o_done;
   logic        o_err;
   logic [1:0]  o_err_code;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   optical_nxn_xbar_cfg_ctrl #(
      .P_PORTS(4),
      .P_SETTLE_CYC(4),
      .P_TIMEOUT(16)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_req(i_req),
      .i_req_valid(i_req_valid),
      .o_req_ready(o_req_ready),
      .o_switch_grant(o_switch_grant),
      .o_grant_valid(o_grant_valid),
      .i_config_end(i_config_end),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_err(o_err),
      .o_err_code(o_err_code)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Step n rising edges, then settle 1 time unit past the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Present a request so it is accepted at the next rising edge (edge T); returns #1 after T.
   task automatic issue(input logic [7:0] req);
      @(negedge i_clk);
      i_req       = req;
      i_req_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
   endtask

   initial begin
      i_rst_n      = 1'b0;
      i_req        = '0;
      i_req_valid  = 1'b0;
      i_config_end = 1'b0;
      #12;
      check_eq("rst_grant", 32'(o_switch_grant), 32'h0000);
      check_eq("rst_ready", 32'(o_req_ready), 32'd1);
      check_eq("rst_busy",  32'(o_busy), 32'd0);
      check_eq("rst_pulses", {29'd0, o_grant_valid, o_done, o_err}, 32'd0);
      check_eq("rst_code",  32'(o_err_code), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Identity permutation
      issue(8'hE4);
      check_eq("id_ready_lo", 32'(o_req_ready), 32'd0);
      check_eq("id_busy", 32'(o_busy), 32'd1);
      edges(1);
      check_eq("id_gvalid", 32'(o_grant_valid), 32'd1);
      check_eq("id_grant", 32'(o_switch_grant), 32'h8421);
      edges(1);
      check_eq("id_gvalid_pulse", 32'(o_grant_valid), 32'd0);
      edges(4);
      check_eq("id_no_early_done", 32'(o_done), 32'd0);
      i_config_end = 1'b1;
      edges(1);
      i_config_end = 1'b0;
      check_eq("id_done", 32'(o_done), 32'd1);
      check_eq("id_ready", 32'(o_req_ready), 32'd1);
      check_eq("id_busy_lo", 32'(o_busy), 32'd0);
      edges(1);
      check_eq("id_done_pulse", 32'(o_done), 32'd0);

      // Reversal with config_end held early
      issue(8'h1B);
      edges(1);
      check_eq("rev_grant", 32'(o_switch_grant), 32'h1248);
      check_eq("rev_gvalid", 32'(o_grant_valid), 32'd1);
      edges(1);
      i_config_end = 1'b1;
      edges(4);
      check_eq("rev_end_ignored", 32'(o_done), 32'd0);
      check_eq("rev_busy", 32'(o_busy), 32'd1);
      edges(1);
      check_eq("rev_done", 32'(o_done), 32'd1);
      i_config_end = 1'b0;

      // Duplicate destination
      edges(1);
      issue(8'h00);
      edges(1);
      check_eq("dup_err", 32'(o_err), 32'd1);
      check_eq("dup_code", 32'(o_err_code), 32'd1);
      check_eq("dup_grant_kept", 32'(o_switch_grant), 32'h1248);
      check_eq("dup_no_gvalid", 32'(o_grant_valid), 32'd0);
      check_eq("dup_ready", 32'(o_req_ready), 32'd1);
      edges(1);
      check_eq("dup_err_pulse", {30'd0, o_err_code}, 32'd0);

      // Timeout
      issue(8'hE4);
      edges(1);
      check_eq("to_grant", 32'(o_switch_grant), 32'h8421);
      edges(20);
      check_eq("to_not_yet", 32'(o_err), 32'd0);
      edges(1);
      check_eq("to_err", 32'(o_err), 32'd1);
      check_eq("to_code", 32'(o_err_code), 32'd2);
      check_eq("to_grant_kept", 32'(o_switch_grant), 32'h8421);
      check_eq("to_ready", 32'(o_req_ready), 32'd1);

      // Same configuration requested again
      edges(1);
      issue(8'hE4);
      edges(1);
`ifdef OPT_XBAR_SKIP_SAME_EN
      check_eq("same_done", 32'(o_done), 32'd1);
      check_eq("same_no_gvalid", 32'(o_grant_valid), 32'd0);
      check_eq("same_ready", 32'(o_req_ready), 32'd1);
`else
      check_eq("same_gvalid", 32'(o_grant_valid), 32'd1);
      check_eq("same_no_done", 32'(o_done), 32'd0);
      check_eq("same_ready_lo", 32'(o_req_ready), 32'd0);
      edges(5);
      i_config_end = 1'b1;
      edges(1);
      i_config_end = 1'b0;
      check_eq("same_done_full", 32'(o_done), 32'd1);
`endif

      // Reset during SETTLE
      edges(1);
      issue(8'h1B);
      edges(3);
      check_eq("rst_mid_busy", 32'(o_busy), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check_eq("rst_mid_grant", 32'(o_switch_grant), 32'h0000);
      check_eq("rst_mid_busy_lo", 32'(o_busy), 32'd0);
      check_eq("rst_mid_ready", 32'(o_req_ready), 32'd1);
      edges(2);
      check_eq("rst_mid_no_pulse", {30'd0, o_done, o_err}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      edges(2);
      check_eq("rst_mid_idle", {29'd0, o_req_ready, o_busy, o_done}, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
